// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_buffer
// Purpose  : Execution trace capture for the 16-bit single-cycle CPU. Once
//            armed, every valid CPU sample {pc, alu, instr, aluop} is written
//            into a circular buffer. A trigger (PC match, opcode match or
//            forced) freezes the window after a programmable number of extra
//            samples. The frozen window is then streamed out oldest-first
//            over a valid/ready port.
// Ports    : clk, reset (async, active-high)
//            capture_en, pc_in, alu_in, instr_in, aluop_in  - CPU sample
//            arm, trig_pc_en/trig_pc, trig_op_en/trig_op,
//            force_trig, post_count                         - control
//            state, triggered, trig_pos, count              - status
//            rd_valid, rd_data, rd_last, rd_ready           - readout stream
// Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer #(
  parameter  int DATA_W  = 16,
  parameter  int OP_W    = 4,
  parameter  int DEPTH   = 16,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = 3*DATA_W + OP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture_en,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic [DATA_W-1:0]  alu_in,
  input  logic [DATA_W-1:0]  instr_in,
  input  logic [OP_W-1:0]    aluop_in,
  input  logic               arm,
  input  logic               trig_pc_en,
  input  logic [DATA_W-1:0]  trig_pc,
  input  logic               trig_op_en,
  input  logic [OP_W-1:0]    trig_op,
  input  logic               force_trig,
  input  logic [PTR_W-1:0]   post_count,
  output logic [2:0]         state,
  output logic               triggered,
  output logic [PTR_W-1:0]   trig_pos,
  output logic [PTR_W:0]     count,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_last,
  input  logic               rd_ready
);

  localparam logic [PTR_W:0]   c_DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_post_rem;
  logic [PTR_W-1:0]     r_post_lat;
  logic [PTR_W-1:0]     r_trig_pos;
  logic [PTR_W:0]       r_count;
  logic [PTR_W:0]       r_rd_rem;
  logic                 r_triggered;

  logic                 w_hit;
  logic                 w_wr;
  logic                 w_enter_done;
  logic                 w_xfer;
  logic                 w_rd_valid;
  logic [PTR_W-1:0]     w_wr_ptr_nxt;
  logic [PTR_W:0]       w_count_nxt;
  logic [PTR_W-1:0]     w_post_used;
  logic [PTR_W-1:0]     w_trig_calc;

  // Match triggers only fire on a valid sample; force fires unconditionally.
  assign w_hit = force_trig
               | (trig_pc_en & capture_en & (pc_in == trig_pc))
               | (trig_op_en & capture_en & (aluop_in == trig_op));

  // rd_valid depends only on registered state, never on rd_ready.
  assign w_rd_valid = (r_state == ST_DONE) && (r_rd_rem != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    if (arm) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED: begin
          w_wr = capture_en;
          if (w_hit) begin
            // A forced trigger on an empty buffer has nothing to wait for.
            if ((post_count == '0) || (!capture_en && (r_count == '0)))
              w_state_nxt = ST_DONE;
            else
              w_state_nxt = ST_POST;
          end
        end
        ST_POST: begin
          w_wr = capture_en;
          if (capture_en && (r_post_rem == c_PTR_ONE))
            w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          if (!w_rd_valid || (rd_ready && (r_rd_rem == c_CNT_ONE)))
            w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
  assign w_xfer       = !arm && w_rd_valid && rd_ready;
  assign w_wr_ptr_nxt = w_wr ? (r_wr_ptr + c_PTR_ONE) : r_wr_ptr;
  assign w_count_nxt  = (w_wr && (r_count != c_DEPTH_CNT)) ? (r_count + c_CNT_ONE) : r_count;
  // In ARMED the post length is still on the input; in POST use the latched copy.
  assign w_post_used  = (r_state == ST_POST) ? r_post_lat : post_count;
  // Modulo-DEPTH arithmetic is exact here: a full buffer has count low bits 0.
  assign w_trig_calc  = w_count_nxt[PTR_W-1:0] - c_PTR_ONE - w_post_used;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_rem  <= '0;
      r_post_lat  <= '0;
      r_trig_pos  <= '0;
      r_count     <= '0;
      r_rd_rem    <= '0;
      r_triggered <= 1'b0;
    end else if (arm) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_rem  <= '0;
      r_post_lat  <= '0;
      r_trig_pos  <= '0;
      r_count     <= '0;
      r_rd_rem    <= '0;
      r_triggered <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      if ((r_state == ST_ARMED) && w_hit) begin
        r_triggered <= 1'b1;
        r_post_rem  <= post_count;
        r_post_lat  <= post_count;
      end else if ((r_state == ST_POST) && capture_en) begin
        r_post_rem  <= r_post_rem - c_PTR_ONE;
      end
      if (w_enter_done) begin
        // Oldest entry sits at the write pointer once the buffer has wrapped.
        r_rd_ptr   <= (w_count_nxt == c_DEPTH_CNT) ? w_wr_ptr_nxt : '0;
        r_rd_rem   <= w_count_nxt;
        r_trig_pos <= (w_count_nxt == '0) ? '0 : w_trig_calc;
      end else if (w_xfer) begin
        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
        r_rd_rem   <= r_rd_rem - c_CNT_ONE;
      end
    end
  end

  // Sample storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= {pc_in, alu_in, instr_in, aluop_in};
  end

  assign state     = r_state;
  assign triggered = r_triggered;
  assign trig_pos  = r_trig_pos;
  assign count     = r_count;
  assign rd_valid  = w_rd_valid;
  assign rd_last   = w_rd_valid && (r_rd_rem == c_CNT_ONE);
  assign rd_data   = w_rd_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire
